data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory controller.
package dmem_pkg;

  // Controller phases: clear walk, two preload writes, then normal service.
  typedef enum logic [1:0] {
    S_CLEAR,
    S_PRE0,
    S_PRE1,
    S_READY
  } dmem_state_t;

  localparam int DMEM_DW        = 8;
  localparam int DMEM_AW        = 8;
  localparam int DMEM_PRE0_ADDR = 16;
  localparam int DMEM_PRE0_VAL  = 254;
  localparam int DMEM_PRE1_ADDR = 244;
  localparam int DMEM_PRE1_VAL  = 5;

endpackage

// File: rtl/dmem_array.sv
// Single-port storage array with registered read and no reset, so it maps
// onto block RAM. Contents are defined only by what the controller writes.
module dmem_array #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write on we; capture the addressed word on re (read data valid next cycle).
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clears the whole array after reset or on request,
// writes two preload words, then serves single-cycle read/write requests.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DW        = DMEM_DW,
  parameter int AW        = DMEM_AW,
  parameter int PRE0_ADDR = DMEM_PRE0_ADDR,
  parameter int PRE0_VAL  = DMEM_PRE0_VAL,
  parameter int PRE1_ADDR = DMEM_PRE1_ADDR,
  parameter int PRE1_VAL  = DMEM_PRE1_VAL
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          init_start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_busy
);

  localparam int DEPTH = 1 << AW;
  // Counter is one bit wider than the address and stops on this compare,
  // so the walk can never wrap back around to address 0.
  localparam logic [AW:0] CLR_LAST = (AW + 1)'(DEPTH - 1);

  dmem_state_t   state, state_next;
  logic [AW:0]   clr_cnt, clr_cnt_next;
  logic          accept;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] rdata_hold;

  assign req_ready = (state == S_READY);
  assign init_busy = (state != S_READY);
  assign accept    = req_valid && req_ready;

  // Next state and write-port mux: walker, preload, or external request.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = req_addr;
    mem_wdata    = req_wdata;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt[AW-1:0];
        mem_wdata = '0;
        if (clr_cnt == CLR_LAST) begin
          state_next = S_PRE0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      S_PRE0: begin
        mem_we     = 1'b1;
        mem_addr   = AW'(PRE0_ADDR);
        mem_wdata  = DW'(PRE0_VAL);
        state_next = S_PRE1;
      end
      S_PRE1: begin
        // Written after PRE0, so PRE1 wins when both addresses coincide.
        mem_we     = 1'b1;
        mem_addr   = AW'(PRE1_ADDR);
        mem_wdata  = DW'(PRE1_VAL);
        state_next = S_READY;
      end
      S_READY: begin
        // A request accepted alongside init_start still completes normally.
        mem_we = accept && req_write;
        mem_re = accept && !req_write;
        if (init_start) begin
          state_next   = S_CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // State and clear-counter registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Response pulse, plus a resettable copy of the last read word to hold
  // rsp_rdata between responses (the array output itself has no reset).
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rdata_hold <= '0;
    end else begin
      rsp_valid <= mem_re;
      if (rsp_valid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  assign rsp_rdata = rsp_valid ? mem_rdata : rdata_hold;

  dmem_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: init latency, preload, read/write,
// back-to-back throughput, init_start and reset during activity.
module tb_data_mem_ctrl;

  logic       CLK;
  logic       reset_n;
  logic       init_start;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_busy;

  int vectors;
  int miscompares;

  data_mem_ctrl dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .init_start (init_start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_busy  (init_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Called at a negedge; counts rising edges until req_ready is seen high.
  task automatic count_to_ready(input int start, output int cnt);
    cnt = start;
    while (!req_ready && cnt < 2000) begin
      @(posedge CLK);
      cnt++;
      @(negedge CLK);
    end
  endtask

  // Called at a negedge; single read, returns the response seen next cycle.
  task automatic do_read(input logic [7:0] a, output logic v, output logic [7:0] d);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    v = rsp_valid;
    d = rsp_rdata;
    $display("read  addr=%0d valid=%0b data=%0d", a, v, d);
  endtask

  // Called at a negedge; single write.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    $display("write addr=%0d data=%0d", a, d);
  endtask

  task automatic test_reset();
    int cnt;
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'd0 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b rdata=%0d ready=%0b busy=%0b, required 0 0 0 1",
               rsp_valid, rsp_rdata, req_ready, init_busy);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    count_to_ready(0, cnt);
    vectors++;
    if (cnt !== 258) begin
      miscompares++;
      $display("FAIL init_latency: ready after %0d cycles, required 258", cnt);
    end
    $display("reset release -> ready after %0d cycles", cnt);
  endtask

  task automatic test_preload();
    logic [7:0] addrs [4];
    logic [7:0] exps  [4];
    logic       v;
    logic [7:0] d;
    addrs = '{8'd0, 8'd16, 8'd244, 8'd255};
    exps  = '{8'd0, 8'd254, 8'd5, 8'd0};
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], v, d);
      vectors++;
      if (v !== 1'b1 || d !== exps[i]) begin
        miscompares++;
        $display("FAIL preload_read addr %0d: valid=%0b data=%0d, required 1 %0d",
                 addrs[i], v, d, exps[i]);
      end
    end
  endtask

  task automatic test_read_after_write();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'd7;
    req_wdata = 8'hA5;
    @(posedge CLK);
    @(negedge CLK);
    $display("write addr=7 data=165");
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL write_no_rsp: rsp_valid=%0b, required 0", rsp_valid);
    end
    req_write = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    $display("read  addr=7 valid=%0b data=%0d", rsp_valid, rsp_rdata);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL raw_read: valid=%0b data=%0h, required 1 a5", rsp_valid, rsp_rdata);
    end
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rdata_hold: valid=%0b data=%0h, required 0 a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'(i);
      req_wdata = 8'(i);
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_write_ready addr %0d: ready=%0b, required 1", i, req_ready);
      end
      @(posedge CLK);
      @(negedge CLK);
      $display("write addr=%0d data=%0d", i, i);
    end
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'(i);
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_read_ready addr %0d: ready=%0b, required 1", i, req_ready);
      end
      @(posedge CLK);
      @(negedge CLK);
      $display("read  addr=%0d valid=%0b data=%0d", i, rsp_valid, rsp_rdata);
      if (rsp_valid === 1'b1) pulses++;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'(i)) begin
        miscompares++;
        $display("FAIL b2b_read addr %0d: valid=%0b data=%0d, required 1 %0d",
                 i, rsp_valid, rsp_rdata, i);
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (pulses !== 256) begin
      miscompares++;
      $display("FAIL b2b_pulses: %0d, required 256", pulses);
    end
  endtask

  task automatic test_init_with_read();
    int         cnt;
    logic       v;
    logic [7:0] d;
    do_write(8'd7, 8'hA5);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 8'd7;
    init_start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid  = 1'b0;
    init_start = 1'b0;
    $display("read  addr=7 with init_start valid=%0b data=%0d", rsp_valid, rsp_rdata);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL init_read: valid=%0b data=%0h ready=%0b busy=%0b, required 1 a5 0 1",
               rsp_valid, rsp_rdata, req_ready, init_busy);
    end
    count_to_ready(0, cnt);
    vectors++;
    if (cnt !== 258) begin
      miscompares++;
      $display("FAIL init_start_latency: ready after %0d cycles, required 258", cnt);
    end
    do_read(8'd7, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 8'd0) begin
      miscompares++;
      $display("FAIL cleared_addr7: valid=%0b data=%0d, required 1 0", v, d);
    end
    do_read(8'd16, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 8'd254) begin
      miscompares++;
      $display("FAIL repreload_16: valid=%0b data=%0d, required 1 254", v, d);
    end
  endtask

  task automatic test_reset_midop();
    int         cnt;
    logic       v;
    logic [7:0] d;
    // Reset while a read response is being presented in S_READY.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd16;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'd254) begin
      miscompares++;
      $display("FAIL pre_reset_rsp: valid=%0b data=%0d, required 1 254", rsp_valid, rsp_rdata);
    end
    reset_n = 1'b0;
    #1;
    $display("reset in ready valid=%0b data=%0d", rsp_valid, rsp_rdata);
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'd0 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: valid=%0b rdata=%0d ready=%0b busy=%0b, required 0 0 0 1",
               rsp_valid, rsp_rdata, req_ready, init_busy);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    // Reset again at clear cycle 100.
    repeat (100) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'd0 || req_ready !== 1'b0 || init_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_clear: valid=%0b rdata=%0d ready=%0b busy=%0b, required 0 0 0 1",
               rsp_valid, rsp_rdata, req_ready, init_busy);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    count_to_ready(0, cnt);
    $display("reset at clear 100 -> ready after %0d cycles", cnt);
    vectors++;
    if (cnt !== 258) begin
      miscompares++;
      $display("FAIL midclear_reset_latency: ready after %0d cycles, required 258", cnt);
    end
    do_read(8'd244, v, d);
    vectors++;
    if (v !== 1'b1 || d !== 8'd5) begin
      miscompares++;
      $display("FAIL post_reset_244: valid=%0b data=%0d, required 1 5", v, d);
    end
  endtask

  task automatic test_init_ignored();
    int cnt;
    init_start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    init_start = 1'b0;
    repeat (50) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    init_start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    init_start = 1'b0;
    vectors++;
    if (init_busy !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_during_clear: busy=%0b ready=%0b, required 1 0", init_busy, req_ready);
    end
    count_to_ready(51, cnt);
    $display("init_start at clear 50 -> ready after %0d cycles", cnt);
    vectors++;
    if (cnt !== 258) begin
      miscompares++;
      $display("FAIL init_ignored_latency: ready after %0d cycles, required 258", cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    init_start  = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 8'd0;
    req_wdata   = 8'd0;
    test_reset();
    test_preload();
    test_read_after_write();
    test_back_to_back();
    test_init_with_read();
    test_reset_midop();
    test_init_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
